// File: rtl/turfio_cin_pkg.sv
// Shared definitions for the TURFIO CIN capture path: training FSM states and
// the default training word, also used by the parallel sync stage.
package turfio_cin_pkg;

  localparam logic [31:0] TRAIN_SEQUENCE_DEFAULT = 32'hA55A6996;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    ARESET  = 4'd1,
    SETTLE  = 4'd2,
    CHECK   = 4'd3,
    SLIP    = 4'd4,
    NEXTOFF = 4'd5,
    LOCKED  = 4'd6,
    RUN     = 4'd7,
    FAIL    = 4'd8
  } cin_train_state_e;

  // True while the alignment search is in progress.
  function automatic logic is_search(input cin_train_state_e st);
    case (st)
      ARESET, SETTLE, CHECK, SLIP, NEXTOFF: is_search = 1'b1;
      default:                              is_search = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/turfio_cin_train_fsm_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_r;

  // Count register: holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (inc && (count_r != {WIDTH{1'b1}})) begin
      count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/turfio_cin_train_fsm.sv
// CIN link training: walks 8 capture offsets x 4 bitslips looking for a run of
// training words, then monitors the link while locked and hands over to data mode.
module turfio_cin_train_fsm
  import turfio_cin_pkg::*;
#(
  parameter logic [31:0] TRAIN_SEQUENCE = TRAIN_SEQUENCE_DEFAULT,
  parameter int unsigned MATCH_COUNT    = 4,
  parameter int unsigned SETTLE_WORDS   = 2
) (
  input  logic        ifclk_i,
  input  logic        ifclk_rstn_i,
  input  logic        train_start_i,
  input  logic        run_i,
  input  logic [31:0] cin_parallel_i,
  input  logic        cin_parallel_valid_i,
  output logic [2:0]  offset_o,
  output logic        rst_bitslip_o,
  output logic        bitslip_o,
  output logic        enable_o,
  output logic        locked_o,
  output logic        fail_o,
  output logic        busy_o,
  output logic [1:0]  slip_count_o,
  output logic [15:0] err_count_o
);

  localparam logic [3:0] MATCH_LAST  = 4'(MATCH_COUNT - 1);
  localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_WORDS - 1);

  cin_train_state_e state_r, state_n;
  logic [2:0] offset_r, offset_n;
  logic [1:0] slip_r, slip_n;
  logic [3:0] match_r, match_n;
  logic [2:0] settle_r, settle_n;
  logic       rst_bitslip_r, bitslip_r, enable_r, locked_r, fail_r, busy_r;
  logic       word_ok_s, word_bad_s, err_inc_s;

  assign word_ok_s  = cin_parallel_valid_i && (cin_parallel_i == TRAIN_SEQUENCE);
  assign word_bad_s = cin_parallel_valid_i && (cin_parallel_i != TRAIN_SEQUENCE);
  assign err_inc_s  = (state_r == LOCKED) && word_bad_s;

  // State and search-position registers; status flags are registered from the next state.
  always_ff @(posedge ifclk_i or negedge ifclk_rstn_i) begin
    if (!ifclk_rstn_i) begin
      state_r       <= IDLE;
      offset_r      <= 3'd0;
      slip_r        <= 2'd0;
      match_r       <= 4'd0;
      settle_r      <= 3'd0;
      rst_bitslip_r <= 1'b0;
      bitslip_r     <= 1'b0;
      enable_r      <= 1'b0;
      locked_r      <= 1'b0;
      fail_r        <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_n;
      offset_r      <= offset_n;
      slip_r        <= slip_n;
      match_r       <= match_n;
      settle_r      <= settle_n;
      rst_bitslip_r <= (state_n == ARESET);
      bitslip_r     <= (state_n == SLIP);
      enable_r      <= (state_n == RUN);
      locked_r      <= (state_n == LOCKED) || (state_n == RUN);
      fail_r        <= (state_n == FAIL);
      busy_r        <= is_search(state_n);
    end
  end

  // Next-state logic; a training request overrides everything else, including run_i.
  always_comb begin
    state_n  = state_r;
    offset_n = offset_r;
    slip_n   = slip_r;
    match_n  = match_r;
    settle_n = settle_r;
    if (train_start_i) begin
      state_n  = ARESET;
      offset_n = 3'd0;
      slip_n   = 2'd0;
      match_n  = 4'd0;
      settle_n = 3'd0;
    end else begin
      case (state_r)
        IDLE: state_n = IDLE;
        ARESET: begin
          state_n  = SETTLE;
          settle_n = 3'd0;
          match_n  = 4'd0;
        end
        SETTLE: begin
          if (!cin_parallel_valid_i) begin
            settle_n = settle_r;
          end else if (settle_r == SETTLE_LAST) begin
            state_n  = CHECK;
            settle_n = 3'd0;
          end else begin
            settle_n = settle_r + 3'd1;
          end
        end
        CHECK: begin
          if (word_ok_s) begin
            if (match_r == MATCH_LAST) begin
              state_n = LOCKED;
            end else begin
              match_n = match_r + 4'd1;
            end
          end else if (word_bad_s) begin
            match_n = 4'd0;
            state_n = (slip_r < 2'd3) ? SLIP : NEXTOFF;
          end else begin
            match_n = match_r;
          end
        end
        SLIP: begin
          slip_n   = slip_r + 2'd1;
          settle_n = 3'd0;
          state_n  = SETTLE;
        end
        NEXTOFF: begin
          if (offset_r < 3'd7) begin
            offset_n = offset_r + 3'd1;
            slip_n   = 2'd0;
            state_n  = ARESET;
          end else begin
            state_n  = FAIL;
          end
        end
        LOCKED:  state_n = run_i ? RUN : LOCKED;
        RUN:     state_n = run_i ? RUN : LOCKED;
        FAIL:    state_n = FAIL;
        default: state_n = IDLE;
      endcase
    end
  end

  sat_counter #(.WIDTH(16)) u_err_count (
    .clk   (ifclk_i),
    .rst_n (ifclk_rstn_i),
    .clr   (train_start_i),
    .inc   (err_inc_s),
    .count (err_count_o)
  );

  assign offset_o      = offset_r;
  assign slip_count_o  = slip_r;
  assign rst_bitslip_o = rst_bitslip_r;
  assign bitslip_o     = bitslip_r;
  assign enable_o      = enable_r;
  assign locked_o      = locked_r;
  assign fail_o        = fail_r;
  assign busy_o        = busy_r;

endmodule

// File: tb/tb_turfio_cin_train_fsm.sv
// Directed bench for the CIN training FSM with a small sync-stage model that
// returns the training word only at a chosen offset/bitslip position.
module tb_turfio_cin_train_fsm;

  localparam logic [31:0] TRAIN = 32'hA55A6996;
  localparam logic [31:0] BAD   = 32'hA55B6997;

  logic        ifclk_i = 1'b0;
  logic        ifclk_rstn_i = 1'b0;
  logic        train_start_i = 1'b0;
  logic        run_i = 1'b0;
  logic [31:0] cin_parallel_i = 32'd0;
  logic        cin_parallel_valid_i = 1'b0;
  logic [2:0]  offset_o;
  logic        rst_bitslip_o, bitslip_o, enable_o, locked_o, fail_o, busy_o;
  logic [1:0]  slip_count_o;
  logic [15:0] err_count_o;

  turfio_cin_train_fsm dut (
    .ifclk_i              (ifclk_i),
    .ifclk_rstn_i         (ifclk_rstn_i),
    .train_start_i        (train_start_i),
    .run_i                (run_i),
    .cin_parallel_i       (cin_parallel_i),
    .cin_parallel_valid_i (cin_parallel_valid_i),
    .offset_o             (offset_o),
    .rst_bitslip_o        (rst_bitslip_o),
    .bitslip_o            (bitslip_o),
    .enable_o             (enable_o),
    .locked_o             (locked_o),
    .fail_o               (fail_o),
    .busy_o               (busy_o),
    .slip_count_o         (slip_count_o),
    .err_count_o          (err_count_o)
  );

  always #5 ifclk_i = ~ifclk_i;

  int checks = 0;
  int errors = 0;
  int n_rst = 0, n_slip = 0, n_overlap = 0, n_wide = 0;
  logic [1:0] model_slip = 2'd0;
  logic prev_rst = 1'b0, prev_slip = 1'b0;

  int align_off = -1, align_slip = 0, corrupt_at = -1, aligned_cnt = 0, words_sent = 0;
  bit slip_any = 1'b0, force_bad = 1'b0;
  int snap_rst, snap_slip, seen;
  bit found;

  // Strobe monitor and aligner model: slips accumulate until the aligner is reset.
  always @(posedge ifclk_i) begin
    if (rst_bitslip_o) n_rst <= n_rst + 1;
    if (bitslip_o) n_slip <= n_slip + 1;
    if (rst_bitslip_o && bitslip_o) n_overlap <= n_overlap + 1;
    if ((rst_bitslip_o && prev_rst) || (bitslip_o && prev_slip)) n_wide <= n_wide + 1;
    if (rst_bitslip_o) model_slip <= 2'd0;
    else if (bitslip_o) model_slip <= model_slip + 2'd1;
    prev_rst  <= rst_bitslip_o;
    prev_slip <= bitslip_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input int gap);
    bit aligned;
    repeat (gap) @(negedge ifclk_i);
    aligned = (align_off >= 0) && (int'(offset_o) == align_off) &&
              (slip_any ? (int'(model_slip) >= align_slip) : (int'(model_slip) == align_slip));
    if (force_bad) begin
      aligned = 1'b0;
    end else if (aligned) begin
      if (aligned_cnt == corrupt_at) aligned = 1'b0;
      aligned_cnt++;
    end
    cin_parallel_i       = aligned ? TRAIN : BAD;
    cin_parallel_valid_i = 1'b1;
    @(negedge ifclk_i);
    cin_parallel_valid_i = 1'b0;
    words_sent++;
  endtask

  task automatic pulse_start();
    @(negedge ifclk_i);
    train_start_i = 1'b1;
    @(negedge ifclk_i);
    train_start_i = 1'b0;
  endtask

  task automatic wait_lock(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (locked_o) break;
      send_word(7);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge ifclk_i);
    chk("rst_offset", 32'(offset_o), 32'd0);
    chk("rst_flags", {26'd0, busy_o, locked_o, fail_o, enable_o, rst_bitslip_o, bitslip_o}, 32'd0);
    chk("rst_err", 32'(err_count_o), 32'd0);
    ifclk_rstn_i = 1'b1;
    repeat (5) @(negedge ifclk_i);
    chk("idle_busy", 32'(busy_o), 32'd0);
    chk("idle_no_strobe", 32'(n_rst + n_slip), 32'd0);

    // Lock at offset 3 / slip 2 after walking offsets 0..2
    align_off = 3; align_slip = 2; slip_any = 1'b0;
    snap_rst = n_rst; snap_slip = n_slip; words_sent = 0;
    pulse_start();
    chk("start_busy", 32'(busy_o), 32'd1);
    wait_lock(200);
    chk("t1_locked", 32'(locked_o), 32'd1);
    chk("t1_offset", 32'(offset_o), 32'd3);
    chk("t1_slip", 32'(slip_count_o), 32'd2);
    chk("t1_busy", 32'(busy_o), 32'd0);
    chk("t1_words", 32'(words_sent), 32'd48);
    chk("t1_rst_pulses", 32'(n_rst - snap_rst), 32'd4);
    chk("t1_slip_pulses", 32'(n_slip - snap_slip), 32'd11);

    // Corrupted word at match=3 forces another slip before lock
    align_off = 3; align_slip = 0; slip_any = 1'b1; corrupt_at = 5; aligned_cnt = 0;
    pulse_start();
    wait_lock(200);
    chk("t2_locked", 32'(locked_o), 32'd1);
    chk("t2_offset", 32'(offset_o), 32'd3);
    chk("t2_slip", 32'(slip_count_o), 32'd1);
    chk("t2_aligned_words", 32'(aligned_cnt), 32'd12);

    // Error counting while locked, freeze in RUN, saturation
    force_bad = 1'b1;
    repeat (5) send_word(0);
    chk("t4_err5", 32'(err_count_o), 32'd5);
    chk("t4_still_locked", 32'(locked_o), 32'd1);
    run_i = 1'b1;
    @(negedge ifclk_i);
    chk("t4_enable", 32'(enable_o), 32'd1);
    repeat (3) send_word(0);
    chk("t4_err_frozen", 32'(err_count_o), 32'd5);
    run_i = 1'b0;
    @(negedge ifclk_i);
    chk("t4_run_exit_enable", 32'(enable_o), 32'd0);
    chk("t4_run_exit_locked", 32'(locked_o), 32'd1);
    repeat (65535) send_word(0);
    chk("t4_err_sat", 32'(err_count_o), 32'h0000FFFF);
    repeat (2) send_word(0);
    chk("t4_err_sat_hold", 32'(err_count_o), 32'h0000FFFF);
    run_i = 1'b1;
    @(negedge ifclk_i);
    chk("t4_enable2", 32'(enable_o), 32'd1);
    repeat (3) send_word(0);
    chk("t4_err_sat_run", 32'(err_count_o), 32'h0000FFFF);

    // train_start beats run_i in RUN
    train_start_i = 1'b1;
    @(negedge ifclk_i);
    train_start_i = 1'b0;
    chk("t5_enable", 32'(enable_o), 32'd0);
    chk("t5_err_clr", 32'(err_count_o), 32'd0);
    chk("t5_areset", {30'd0, busy_o, rst_bitslip_o}, 32'd3);
    chk("t5_unlocked", 32'(locked_o), 32'd0);
    run_i = 1'b0;

    // Exhaustive search without a match ends in FAIL after 96 words
    repeat (4) @(negedge ifclk_i);
    snap_rst = n_rst; snap_slip = n_slip;
    pulse_start();
    for (int i = 1; i <= 96; i++) begin
      send_word(7);
      if (i == 95) chk("t3_no_fail_early", 32'(fail_o), 32'd0);
    end
    repeat (2) @(negedge ifclk_i);
    chk("t3_fail", 32'(fail_o), 32'd1);
    chk("t3_offset", 32'(offset_o), 32'd7);
    chk("t3_busy", 32'(busy_o), 32'd0);
    chk("t3_rst_pulses", 32'(n_rst - snap_rst), 32'd8);
    chk("t3_slip_pulses", 32'(n_slip - snap_slip), 32'd24);

    // Reset asserted during the second SLIP
    pulse_start();
    cin_parallel_i = BAD;
    cin_parallel_valid_i = 1'b1;
    found = 1'b0; seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge ifclk_i);
      if (bitslip_o) seen++;
      if (seen == 2) begin found = 1'b1; break; end
    end
    chk("t6_slip_found", 32'(found), 32'd1);
    chk("t6_slip_cnt_pre", 32'(slip_count_o), 32'd1);
    #1 ifclk_rstn_i = 1'b0;
    #1;
    chk("t6_async_flags", {26'd0, busy_o, locked_o, fail_o, enable_o, rst_bitslip_o, bitslip_o}, 32'd0);
    chk("t6_async_cnt", {27'd0, offset_o, slip_count_o}, 32'd0);
    cin_parallel_valid_i = 1'b0;
    @(negedge ifclk_i);
    ifclk_rstn_i = 1'b1;
    snap_rst = n_rst; snap_slip = n_slip;
    repeat (40) send_word(0);
    chk("t6_no_strobe", 32'(n_rst - snap_rst + n_slip - snap_slip), 32'd0);
    chk("t6_idle", 32'(busy_o), 32'd0);

    chk("strobe_overlap", 32'(n_overlap), 32'd0);
    chk("strobe_width", 32'(n_wide), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
